// File: rtl/frame_buffer_matrix3_controller_pkg.sv
// Shared types and slot arithmetic for the 3-row line buffer controller.
// Build option used by the top: FB_CTRL_OVERRUN_DETECT_EN.
package frame_buffer_matrix3_controller_pkg;

  localparam int P_FRAME_BUFFER_ROWS = 3;
  localparam int SLOT_BITS           = 2;

  typedef logic [SLOT_BITS-1:0] slot_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic slot_t slot_inc(input slot_t s);
    slot_t r;
    if (s == SLOT_BITS'(P_FRAME_BUFFER_ROWS - 1)) begin
      r = SLOT_BITS'(0);
    end else begin
      r = s + SLOT_BITS'(1);
    end
    return r;
  endfunction

  function automatic slot_t slot_dec(input slot_t s);
    slot_t r;
    if (s == SLOT_BITS'(0)) begin
      r = SLOT_BITS'(P_FRAME_BUFFER_ROWS - 1);
    end else begin
      r = s - SLOT_BITS'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_buffer_matrix3_controller_if.sv
// Pixel-side inputs and buffer/window outputs of the line buffer controller.
// master = controller side, slave = environment side.
interface frame_buffer_matrix3_controller_if #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480
);
  localparam int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS);
  localparam int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS);

  logic                           I_PIXEL_CLK;
  logic                           I_DATA_VALID;
  logic                           I_FRAME_START;
  logic [P_FRAME_COLUMN_BITS-1:0] O_BUF_COLUMN;
  logic [1:0]                     O_BUF_SLOT;
  logic                           O_WRITE_ENABLE;
  logic                           O_READ_ENABLE;
  logic [P_FRAME_COLUMN_BITS-1:0] O_MATRIX_COLUMN;
  logic [P_FRAME_ROW_BITS-1:0]    O_MATRIX_ROW;
  logic                           O_MATRIX_VALID;
  logic                           O_BUSY;
  logic                           O_OVERRUN;

  modport master (
    input  I_PIXEL_CLK, I_DATA_VALID, I_FRAME_START,
    output O_BUF_COLUMN, O_BUF_SLOT, O_WRITE_ENABLE, O_READ_ENABLE,
           O_MATRIX_COLUMN, O_MATRIX_ROW, O_MATRIX_VALID, O_BUSY, O_OVERRUN
  );

  modport slave (
    output I_PIXEL_CLK, I_DATA_VALID, I_FRAME_START,
    input  O_BUF_COLUMN, O_BUF_SLOT, O_WRITE_ENABLE, O_READ_ENABLE,
           O_MATRIX_COLUMN, O_MATRIX_ROW, O_MATRIX_VALID, O_BUSY, O_OVERRUN
  );

endinterface

// File: rtl/frame_buffer_matrix3_controller_pixel_clock_edge_detector.sv
// Brings the pixel clock and its data-valid flag into the system clock domain and
// produces a one-cycle pulse per pixel-clock rising edge, aligned with the synced valid.
module frame_buffer_matrix3_controller_pixel_clock_edge_detector (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pixel_clk_i,
  input  logic data_valid_i,
  output logic pix_edge_o,
  output logic data_valid_o
);

  logic [2:0] sync_q;
  logic [1:0] dv_q;

  // Synchroniser chains; the valid chain is two deep so it lines up with sync_q[1].
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 3'b000;
      dv_q   <= 2'b00;
    end else begin
      sync_q <= {sync_q[1:0], pixel_clk_i};
      dv_q   <= {dv_q[0], data_valid_i};
    end
  end

  assign pix_edge_o   = sync_q[1] & ~sync_q[2];
  assign data_valid_o = dv_q[1];

endmodule

// File: rtl/frame_buffer_matrix3_controller.sv
// Write/read sequencer for the 3-row grayscale line buffer feeding the Sobel stage.
// Optional sticky overrun flag built only when FB_CTRL_OVERRUN_DETECT_EN is defined.
module frame_buffer_matrix3_controller
  import frame_buffer_matrix3_controller_pkg::*;
#(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480,
  parameter int P_READ_LATENCY  = 1
) (
  input logic                         I_CLK,
  input logic                         I_RESET_N,
  frame_buffer_matrix3_controller_if.master bus
);

  localparam int COL_BITS  = $clog2(P_FRAME_COLUMNS);
  localparam int ROW_BITS  = $clog2(P_FRAME_ROWS);
  localparam int WAIT_BITS = (P_READ_LATENCY > 1) ? $clog2(P_READ_LATENCY) : 1;
  localparam logic [COL_BITS-1:0]  L_LAST_COL  = COL_BITS'(P_FRAME_COLUMNS - 1);
  localparam logic [ROW_BITS-1:0]  L_LAST_ROW  = ROW_BITS'(P_FRAME_ROWS - 1);
  localparam logic [WAIT_BITS-1:0] L_LAST_WAIT = WAIT_BITS'(P_READ_LATENCY - 1);

  logic pix_edge_s;
  logic data_valid_s;
  logic valid_pixel_s;

  state_e               state_q, state_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  slot_t                slot_q, slot_d;
  logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic [COL_BITS-1:0]  buf_col_q, buf_col_d;
  slot_t                buf_slot_q, buf_slot_d;
  logic [COL_BITS-1:0]  mcol_q, mcol_d;
  logic [ROW_BITS-1:0]  mrow_q, mrow_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 mv_q, mv_d;
  logic                 busy_q, busy_d;

  frame_buffer_matrix3_controller_pixel_clock_edge_detector u_edge (
    .clk_i        (I_CLK),
    .rst_n_i      (I_RESET_N),
    .pixel_clk_i  (bus.I_PIXEL_CLK),
    .data_valid_i (bus.I_DATA_VALID),
    .pix_edge_o   (pix_edge_s),
    .data_valid_o (data_valid_s)
  );

  assign valid_pixel_s = pix_edge_s & data_valid_s;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    slot_d     = slot_q;
    wait_cnt_d = wait_cnt_q;
    buf_col_d  = buf_col_q;
    buf_slot_d = buf_slot_q;
    mcol_d     = mcol_q;
    mrow_d     = mrow_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    mv_d       = 1'b0;
    if (bus.I_FRAME_START) begin
      col_d      = COL_BITS'(0);
      row_d      = ROW_BITS'(0);
      slot_d     = SLOT_BITS'(0);
      wait_cnt_d = WAIT_BITS'(0);
      if (valid_pixel_s) begin
        state_d    = WRITE;
        wr_en_d    = 1'b1;
        buf_col_d  = COL_BITS'(0);
        buf_slot_d = SLOT_BITS'(0);
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_pixel_s) begin
            state_d    = WRITE;
            wr_en_d    = 1'b1;
            buf_col_d  = col_q;
            buf_slot_d = slot_q;
          end else begin
            state_d = IDLE;
          end
        end
        WRITE: begin
          if (col_q == L_LAST_COL) begin
            col_d = COL_BITS'(0);
            if (row_q == L_LAST_ROW) begin
              row_d  = ROW_BITS'(0);
              slot_d = SLOT_BITS'(0);
            end else begin
              row_d  = row_q + ROW_BITS'(1);
              slot_d = slot_inc(slot_q);
            end
          end else begin
            col_d = col_q + COL_BITS'(1);
          end
          // A full 3x3 window exists once two prior rows and columns are stored.
          if ((col_q >= COL_BITS'(2)) && (row_q >= ROW_BITS'(2))) begin
            state_d    = READ;
            rd_en_d    = 1'b1;
            buf_col_d  = col_q - COL_BITS'(1);
            buf_slot_d = slot_dec(slot_q);
            mcol_d     = col_q - COL_BITS'(1);
            mrow_d     = row_q - ROW_BITS'(1);
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_BITS'(0);
        end
        WAIT: begin
          if (wait_cnt_q == L_LAST_WAIT) begin
            state_d = DONE;
            mv_d    = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q    <= IDLE;
      col_q      <= COL_BITS'(0);
      row_q      <= ROW_BITS'(0);
      slot_q     <= SLOT_BITS'(0);
      wait_cnt_q <= WAIT_BITS'(0);
      buf_col_q  <= COL_BITS'(0);
      buf_slot_q <= SLOT_BITS'(0);
      mcol_q     <= COL_BITS'(0);
      mrow_q     <= ROW_BITS'(0);
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      mv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      slot_q     <= slot_d;
      wait_cnt_q <= wait_cnt_d;
      buf_col_q  <= buf_col_d;
      buf_slot_q <= buf_slot_d;
      mcol_q     <= mcol_d;
      mrow_q     <= mrow_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      mv_q       <= mv_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.O_BUF_COLUMN    = buf_col_q;
  assign bus.O_BUF_SLOT      = buf_slot_q;
  assign bus.O_WRITE_ENABLE  = wr_en_q;
  assign bus.O_READ_ENABLE   = rd_en_q;
  assign bus.O_MATRIX_COLUMN = mcol_q;
  assign bus.O_MATRIX_ROW    = mrow_q;
  assign bus.O_MATRIX_VALID  = mv_q;
  assign bus.O_BUSY          = busy_q;

`ifdef FB_CTRL_OVERRUN_DETECT_EN
  logic overrun_q, overrun_d;

  // A valid pixel seen outside IDLE is dropped; remember it until frame start.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.I_FRAME_START) begin
      overrun_d = 1'b0;
    end else if (valid_pixel_s && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Sticky overrun register.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.O_OVERRUN = overrun_q;
`else
  assign bus.O_OVERRUN = 1'b0;
`endif

endmodule
